// File: rtl/gcd_if.sv
// Host-side operand/result bundle for the subtraction GCD unit.
interface gcd_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             done;

    modport master (
        output start,
        output data_in,
        input  a_out,
        input  b_out,
        input  done
    );

    modport slave (
        input  start,
        input  data_in,
        output a_out,
        output b_out,
        output done
    );
endinterface

// File: rtl/gcd_unit.sv
// Iterative unsigned GCD by repeated subtraction.
// Operands arrive serially on data_in; result is held on a_out with done.
module gcd_unit #(
    parameter int WIDTH = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    gcd_if.slave  io
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        COMPARE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic             eq, gt, a_zero, b_zero;
    logic [WIDTH-1:0] a_minus_b, b_minus_a;

    assign eq        = (a_q == b_q);
    assign gt        = (a_q > b_q);
    assign a_zero    = (a_q == '0);
    assign b_zero    = (b_q == '0);
    assign a_minus_b = a_q - b_q;
    assign b_minus_a = b_q - a_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            IDLE: begin
                if (io.start) state_d = LOAD_A;
            end
            LOAD_A: begin
                a_d     = io.data_in;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                b_d     = io.data_in;
                state_d = COMPARE;
            end
            COMPARE: begin
                // Zero checks precede subtraction so gcd(x,0) and gcd(0,x) terminate
                if (eq) begin
                    state_d = DONE;
                end else if (b_zero) begin
                    state_d = DONE;
                end else if (a_zero) begin
                    a_d     = b_q;
                    state_d = DONE;
                end else if (gt) begin
                    a_d = a_minus_b;
                end else begin
                    b_d = b_minus_a;
                end
            end
            DONE: begin
                if (!io.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.a_out = a_q;
    assign io.b_out = b_q;
    assign io.done  = (state_q == DONE);

endmodule

// File: tb/tb_gcd_unit.sv
// Scoreboard bench for gcd_unit: expected GCDs queued at launch,
// popped and compared when done rises.
module tb_gcd_unit;

    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;

    gcd_if #(.WIDTH(WIDTH)) bus ();

    gcd_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q[$];

    function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] p, q, t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Drive start and both operands; returns with the unit in COMPARE.
    task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.data_in = x;
        @(negedge clk);
        bus.data_in = y;
        @(negedge clk);
        exp_q.push_back(gcd_ref(x, y));
    endtask

    task automatic wait_done(input string name, input int budget,
                             input bit toggle, output int cycles);
        logic [WIDTH-1:0] exp;
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < budget) begin
            if (toggle) bus.start = ~bus.start;
            @(negedge clk);
            cycles++;
        end
        total++;
        exp = exp_q.pop_front();
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: done=%b after %0d cycles", name, bus.done, cycles);
        end else if (bus.a_out !== exp) begin
            bad++;
            $display("FAIL %s result: a_out=%0d want %0d", name, bus.a_out, exp);
        end
    endtask

    task automatic release_start(input string name);
        bus.start = 1'b0;
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL %s idle: done=%b want 0", name, bus.done);
        end
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (bus.a_out !== 0 || bus.b_out !== 0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset: a=%0d b=%0d done=%b want 0 0 0",
                     bus.a_out, bus.b_out, bus.done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_timing;
        logic [WIDTH-1:0] ta[6];
        logic [WIDTH-1:0] tb[6];
        logic [WIDTH-1:0] exp;
        ta = '{65, 65, 52, 39, 26, 13};
        tb = '{78, 13, 13, 13, 13, 13};
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 143;
        exp_q.push_back(gcd_ref(143, 78));
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if (bus.a_out !== 143) begin
            bad++;
            $display("FAIL basic load_a: a=%0d want 143", bus.a_out);
        end
        bus.data_in = 78;
        @(posedge clk);
        #1;
        total++;
        if (bus.b_out !== 78) begin
            bad++;
            $display("FAIL basic load_b: b=%0d want 78", bus.b_out);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.a_out !== ta[i] || bus.b_out !== tb[i] || bus.done !== 1'b0) begin
                bad++;
                $display("FAIL basic step%0d: a=%0d b=%0d done=%b want %0d %0d 0",
                         i, bus.a_out, bus.b_out, bus.done, ta[i], tb[i]);
            end
        end
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        total++;
        if (bus.done !== 1'b1 || bus.a_out !== exp) begin
            bad++;
            $display("FAIL basic done: done=%b a=%0d want 1 %0d", bus.done, bus.a_out, exp);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL basic hold: done=%b want 1", bus.done);
        end
        @(negedge clk);
        release_start("basic");
    endtask

    task automatic test_equal;
        int c;
        launch(21, 21);
        wait_done("equal", 20, 1'b0, c);
        total++;
        if (c != 1) begin
            bad++;
            $display("FAIL equal latency: cycles=%0d want 1", c);
        end
        release_start("equal");
    endtask

    task automatic test_zero;
        logic [WIDTH-1:0] xs[3];
        logic [WIDTH-1:0] ys[3];
        int c;
        xs = '{0, 36, 0};
        ys = '{36, 0, 0};
        for (int i = 0; i < 3; i++) begin
            launch(xs[i], ys[i]);
            wait_done($sformatf("zero%0d", i), 20, 1'b0, c);
            release_start($sformatf("zero%0d", i));
        end
    endtask

    task automatic test_worst;
        int c;
        launch(16'hFFFF, 1);
        wait_done("worst", 70000, 1'b0, c);
        total++;
        if (c != 65535 || bus.b_out !== 1) begin
            bad++;
            $display("FAIL worst: cycles=%0d b=%0d want 65535 1", c, bus.b_out);
        end
        release_start("worst");
    endtask

    task automatic test_abort;
        int c;
        launch(1000, 3);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.a_out !== 0 || bus.b_out !== 0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL abort: a=%0d b=%0d done=%b want 0 0 0",
                     bus.a_out, bus.b_out, bus.done);
        end
        exp_q.delete();
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        launch(48, 18);
        wait_done("restart", 100, 1'b0, c);
        release_start("restart");
    endtask

    task automatic test_handshake;
        int c;
        launch(100, 75);
        wait_done("handshake", 100, 1'b1, c);
        bus.start = 1'b1;
        @(negedge clk);
        total++;
        if (bus.done !== 1'b1 || bus.a_out !== 25) begin
            bad++;
            $display("FAIL handshake hold: done=%b a=%0d want 1 25", bus.done, bus.a_out);
        end
        release_start("handshake");
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = '0;
        test_reset();
        test_basic_timing();
        test_equal();
        test_zero();
        test_worst();
        test_abort();
        test_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcd_unit.md
Name: gcd_unit

Overview:
- Iterative unsigned GCD engine using the subtraction (Euclid) method.
- Controller FSM and datapath (A/B registers, comparator, subtractor, load muxes) live in one block.
- Operands arrive serially on one shared input bus on consecutive cycles after `start`.
- The result is presented on `a_out` with a `done` flag. The block is a leaf compute unit for a host that sequences operands.

Parameters:
- WIDTH, 16, operand/result width in bits (unsigned).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level request; sampled in IDLE to begin an operation
- data_in  input  WIDTH  operand bus: A on the first load cycle, B on the second
- a_out  output  WIDTH  A register contents; holds GCD when done=1
- b_out  output  WIDTH  B register contents (debug/visibility)
- done  output  1  high while in DONE state

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; A=0, B=0, done=0.
  - Applies at any time, including mid-computation; operation is aborted with no residue.
- States: IDLE, LOAD_A, LOAD_B, COMPARE, DONE. All transitions on rising clk.
- IDLE:
  - done=0; A/B hold.
  - start=1 at edge -> LOAD_A.
- LOAD_A: at next edge, A<=data_in; -> LOAD_B.
- LOAD_B: at next edge, B<=data_in; -> COMPARE.
- COMPARE: one action per cycle, using registered A and B. Priority order:
  1. A==B -> DONE; registers hold.
  2. B==0 -> DONE; A holds, so gcd(x,0)=x.
  3. A==0 -> A<=B; -> DONE, so gcd(0,x)=x and gcd(0,0)=0.
  4. A>B -> A<=A-B; stay in COMPARE.
  5. A<B -> B<=B-A; stay in COMPARE.
- Arithmetic rules:
  - Subtraction is always larger minus smaller, so no underflow.
  - WIDTH-bit unsigned results; no carry out.
- DONE:
  - done=1; A/B hold; a_out = GCD.
  - Stays in DONE while start=1.
  - start=0 at edge -> IDLE; done drops one cycle later with the state.
  - A new operation requires start to go low, then high again.
- start is ignored in LOAD_A, LOAD_B and COMPARE.
- data_in is ignored outside LOAD_A and LOAD_B.
- Latency:
  - First edge with start=1: IDLE->LOAD_A.
  - +1 edge loads A, +1 edge loads B.
  - Then N subtraction edges, then 1 edge into DONE.
  - Worst case N = 2^WIDTH-2, e.g. (65535,1).
- Outputs are registered or decoded directly from the state register; no combinational path from inputs to outputs.
- Comparator (gt/lt/eq) and subtractor are internal combinational logic, one shared compare per cycle.

Test Plan:
- Basic timing, 10 ns period, edges at 5, 15, 25, …:
  - Stimulus: start=1 from t=3; data_in=143 before edge 15 and 78 before edge 25.
  - Sequence: A=143 at edge 15, B=78 at edge 25.
  - Then (A,B) = (65,78), (65,13), (52,13), (39,13), (26,13), (13,13) on edges 35 through 85.
  - done=1 from edge 95 with a_out=13; done stays high while start stays 1.
- Equal operands (A=B=21): DONE one edge after the B load; a_out=21; zero subtractions.
- Zero operands:
  - (0,36) -> a_out=36.
  - (36,0) -> a_out=36.
  - (0,0) -> a_out=0, done asserted.
  - All complete without hanging.
- Coprime worst case with WIDTH=16: (65535,1) -> a_out=1 after 65534 subtract cycles; b_out=1.
- Abort and restart:
  - Drop rst_n mid-COMPARE -> A=B=0, done=0 immediately, without waiting for clk.
  - Release reset, run (48,18) -> a_out=6.
- Handshake:
  - After DONE, start=0 -> IDLE and done=0.
  - start=1 with (100,75) -> a_out=25.
  - Toggling start during COMPARE has no effect.
